// File: rtl/tx_slot_scheduler.sv
// TDMA transmit scheduler: fixed-priority arbitration of pending TX requests, wait for this node's
// timeslot, carrier sense, then a single transmission handed to the radio.
module tx_slot_scheduler #(
  parameter int WORD_WIDTH   = 16,
  parameter int SLOT_CYCLES  = 64,
  parameter int NUM_SLOTS    = 16,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] myTimeslot,
  input  logic [3:0]            req,
  input  logic                  channel_clear,
  input  logic                  tx_done,
  output logic                  tx_start,
  output logic [2:0]            tx_type,
  output logic [3:0]            grant,
  output logic [3:0]            ack,
  output logic [WORD_WIDTH-1:0] slot_count,
  output logic                  in_my_slot,
  output logic                  busy,
  output logic [2:0]            o_dbg_state
);

  // Handshake: a requester raises its req bit and holds it until it sees its ack bit for one
  // cycle; dropping req before the transmission starts withdraws it without an ack.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_SLOT = 3'd1,
    S_SENSE     = 3'd2,
    S_TX        = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [WORD_WIDTH-1:0] LP_CYC_LAST     = WORD_WIDTH'(SLOT_CYCLES - 1);
  localparam logic [WORD_WIDTH-1:0] LP_SLOT_LAST    = WORD_WIDTH'(NUM_SLOTS - 1);
  localparam logic [WORD_WIDTH-1:0] LP_GUARD_START  = WORD_WIDTH'(SLOT_CYCLES - GUARD_CYCLES);

  localparam logic [2:0] LP_TYPE_SOS  = 3'b110;
  localparam logic [2:0] LP_TYPE_DATA = 3'b101;
  localparam logic [2:0] LP_TYPE_MR   = 3'b011;
  localparam logic [2:0] LP_TYPE_HB   = 3'b000;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WORD_WIDTH-1:0] r_cycle_cnt;
  logic [WORD_WIDTH-1:0] r_slot_count;
  logic [3:0]            r_grant;
  logic [3:0]            w_grant_nxt;
  logic [2:0]            r_tx_type;
  logic [2:0]            w_tx_type_nxt;
  logic                  r_tx_start;
  logic                  w_tx_start_nxt;
  logic [3:0]            w_winner;
  logic [2:0]            w_winner_type;
  logic                  w_withdrawn;
  logic                  w_before_guard;
  logic                  w_in_my_slot;

  // Slot timer; cleared whenever the scheduler is disabled.
  always_ff @(posedge clk) begin
    if (!nrst || !en) begin
      r_cycle_cnt  <= '0;
      r_slot_count <= '0;
    end else if (r_cycle_cnt == LP_CYC_LAST) begin
      r_cycle_cnt <= '0;
      if (r_slot_count == LP_SLOT_LAST) begin
        r_slot_count <= '0;
      end else begin
        r_slot_count <= r_slot_count + 1'b1;
      end
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  // A myTimeslot outside 0..NUM_SLOTS-1 can never equal the slot counter, so it never matches.
  assign w_in_my_slot   = en && (r_slot_count == myTimeslot);
  assign w_before_guard = (r_cycle_cnt < LP_GUARD_START);
  assign w_withdrawn    = ~|(req & r_grant);

  // Lowest set request bit wins.
  always_comb begin
    w_winner      = 4'b0000;
    w_winner_type = LP_TYPE_HB;
    if (req[0]) begin
      w_winner      = 4'b0001;
      w_winner_type = LP_TYPE_SOS;
    end else if (req[1]) begin
      w_winner      = 4'b0010;
      w_winner_type = LP_TYPE_DATA;
    end else if (req[2]) begin
      w_winner      = 4'b0100;
      w_winner_type = LP_TYPE_MR;
    end else if (req[3]) begin
      w_winner      = 4'b1000;
      w_winner_type = LP_TYPE_HB;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_tx_type  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_tx_type  <= w_tx_type_nxt;
      r_tx_start <= w_tx_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_tx_type_nxt  = r_tx_type;
    w_tx_start_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && (|req)) begin
          w_grant_nxt   = w_winner;
          w_tx_type_nxt = w_winner_type;
          w_state_nxt   = S_WAIT_SLOT;
        end
      end
      S_WAIT_SLOT: begin
        if (w_withdrawn) begin
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = '0;
          w_tx_type_nxt = '0;
        end else if (w_in_my_slot && w_before_guard) begin
          w_state_nxt = S_SENSE;
        end
      end
      S_SENSE: begin
        // Decisions use the registered timer values, so a slot wrap on this edge is not seen yet.
        if (w_withdrawn) begin
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = '0;
          w_tx_type_nxt = '0;
        end else if (channel_clear) begin
          w_state_nxt    = S_TX;
          w_tx_start_nxt = 1'b1;
        end else if (!w_before_guard) begin
          w_state_nxt = S_WAIT_SLOT;
        end
      end
      S_TX: begin
        if (tx_done) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt   = S_IDLE;
        w_grant_nxt   = '0;
        w_tx_type_nxt = '0;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_grant_nxt   = '0;
        w_tx_type_nxt = '0;
      end
    endcase
    // Disabling abandons whatever is in progress, including a transmission in flight.
    if (!en) begin
      w_state_nxt    = S_IDLE;
      w_grant_nxt    = '0;
      w_tx_type_nxt  = '0;
      w_tx_start_nxt = 1'b0;
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_type     = r_tx_type;
  assign grant       = r_grant;
  assign ack         = ((r_state == S_DONE) && en) ? r_grant : 4'b0000;
  assign slot_count  = r_slot_count;
  assign in_my_slot  = w_in_my_slot;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tx_slot_scheduler.sv
// Directed bench for tx_slot_scheduler: arbitration vector table plus hand-written slot/sense,
// withdrawal, reset and enable sequences against a small slot-timer model.
module tb_tx_slot_scheduler;

  localparam int WW = 16;
  localparam int SC = 8;
  localparam int NS = 4;
  localparam int GC = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_SENSE = 3'd2;
  localparam logic [2:0] ST_TX    = 3'd3;

  logic          clk;
  logic          nrst;
  logic          en;
  logic [WW-1:0] myTimeslot;
  logic [3:0]    req;
  logic          channel_clear;
  logic          tx_done;
  logic          tx_start;
  logic [2:0]    tx_type;
  logic [3:0]    grant;
  logic [3:0]    ack;
  logic [WW-1:0] slot_count;
  logic          in_my_slot;
  logic          busy;
  logic [2:0]    dbg_state;

  int n_checks;
  int n_errors;
  int m_cyc;
  int m_slot;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [2:0] exp_type;
  } arb_vec_t;

  arb_vec_t vecs[10];

  tx_slot_scheduler #(
    .WORD_WIDTH  (WW),
    .SLOT_CYCLES (SC),
    .NUM_SLOTS   (NS),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .myTimeslot   (myTimeslot),
    .req          (req),
    .channel_clear(channel_clear),
    .tx_done      (tx_done),
    .tx_start     (tx_start),
    .tx_type      (tx_type),
    .grant        (grant),
    .ack          (ack),
    .slot_count   (slot_count),
    .in_my_slot   (in_my_slot),
    .busy         (busy),
    .o_dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: advance the slot-timer model at the edge, then check timer outputs 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (!nrst || !en) begin
      m_cyc  = 0;
      m_slot = 0;
    end else if (m_cyc == SC - 1) begin
      m_cyc  = 0;
      m_slot = (m_slot + 1) % NS;
    end else begin
      m_cyc++;
    end
    #1;
    chk("slot_count", 32'(slot_count), 32'(m_slot));
    chk("in_my_slot", 32'(in_my_slot), 32'(en && (32'(myTimeslot) == 32'(m_slot))));
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic wait_tx_start(input int budget, input string name);
    int n = 0;
    while (tx_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_tx_start_seen"}, 32'(tx_start), 32'd1);
  endtask

  // Waits for the transmission, completes it with tx_done and checks the ack pulse.
  task automatic serve(input string name, input int exp_slot, input logic [3:0] exp_ack);
    wait_tx_start(40, name);
    chk({name, "_start_slot"}, 32'(slot_count), 32'(exp_slot));
    chk({name, "_start_in_my_slot"}, 32'(in_my_slot), 32'd1);
    tick();
    chk({name, "_start_single"}, 32'(tx_start), 32'd0);
    chk({name, "_in_tx"}, 32'(dbg_state), 32'(ST_TX));
    chk({name, "_no_early_ack"}, 32'(ack), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk({name, "_ack"}, 32'(ack), 32'(exp_ack));
    req = req & ~exp_ack;
    tick();
    chk({name, "_ack_one_cycle"}, 32'(ack), 32'd0);
    chk({name, "_grant_cleared"}, 32'(grant), 32'd0);
    chk({name, "_idle_after_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int    n_start;
    int    found;
    int    ret_cyc;
    int    ret_slot;
    int    n_not_wait;
    logic [2:0] prev_st;

    vecs[0] = '{4'b0001, 4'b0001, 3'b110};
    vecs[1] = '{4'b0010, 4'b0010, 3'b101};
    vecs[2] = '{4'b0100, 4'b0100, 3'b011};
    vecs[3] = '{4'b1000, 4'b1000, 3'b000};
    vecs[4] = '{4'b0110, 4'b0010, 3'b101};
    vecs[5] = '{4'b1010, 4'b0010, 3'b101};
    vecs[6] = '{4'b1100, 4'b0100, 3'b011};
    vecs[7] = '{4'b1111, 4'b0001, 3'b110};
    vecs[8] = '{4'b1001, 4'b0001, 3'b110};
    vecs[9] = '{4'b1110, 4'b0010, 3'b101};

    n_checks = 0;
    n_errors = 0;
    m_cyc = 0;
    m_slot = 0;
    nrst = 1'b0;
    en = 1'b0;
    myTimeslot = 16'd2;
    req = 4'b0000;
    channel_clear = 1'b0;
    tx_done = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_type", 32'(tx_type), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    nrst = 1'b1;
    en = 1'b1;

    // Out-of-range timeslot never matches: stays in WAIT_SLOT for over a frame.
    myTimeslot = 16'd5;
    channel_clear = 1'b1;
    req = 4'b0001;
    tick();
    n_not_wait = 0;
    n_start = 0;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (dbg_state !== ST_WAIT) n_not_wait++;
      if (tx_start === 1'b1) n_start++;
    end
    chk("oor_slot_stays_wait", 32'(n_not_wait), 32'd0);
    chk("oor_slot_no_start", 32'(n_start), 32'd0);
    req = 4'b0000;
    tick();
    chk("oor_withdraw_idle", 32'(busy), 32'd0);

    // Arbitration table: latch then withdraw in WAIT_SLOT.
    for (int i = 0; i < 10; i++) begin
      req = vecs[i].req;
      tick();
      chk($sformatf("arb%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      chk($sformatf("arb%0d_type", i), 32'(tx_type), 32'(vecs[i].exp_type));
      chk($sformatf("arb%0d_state", i), 32'(dbg_state), 32'(ST_WAIT));
      req = 4'b0000;
      tick();
      chk($sformatf("arb%0d_withdraw_grant", i), 32'(grant), 32'd0);
      chk($sformatf("arb%0d_withdraw_busy", i), 32'(busy), 32'd0);
      chk($sformatf("arb%0d_withdraw_ack", i), 32'(ack), 32'd0);
    end

    // 1: data beats MR; served in slot 2, then MR granted.
    do_reset();
    myTimeslot = 16'd2;
    channel_clear = 1'b1;
    req = 4'b0110;
    tick();
    chk("t1_grant", 32'(grant), 32'b0010);
    chk("t1_type", 32'(tx_type), 32'b101);
    wait_tx_start(40, "t1");
    chk("t1_cyc_before_guard", 32'(m_cyc <= 6), 32'd1);
    serve("t1", 2, 4'b0010);
    tick();
    chk("t1_next_grant", 32'(grant), 32'b0100);
    chk("t1_next_type", 32'(tx_type), 32'b011);
    req = 4'b0000;
    tick();

    // 2: busy channel through slot 1, retry next frame.
    do_reset();
    myTimeslot = 16'd1;
    channel_clear = 1'b0;
    req = 4'b1000;
    tick();
    chk("t2_grant", 32'(grant), 32'b1000);
    chk("t2_type", 32'(tx_type), 32'b000);
    n_start = 0;
    found = 0;
    ret_cyc = -1;
    ret_slot = -1;
    for (int i = 0; i < 24 && found == 0; i++) begin
      prev_st = dbg_state;
      tick();
      if (tx_start === 1'b1) n_start++;
      if (prev_st == ST_SENSE && dbg_state == ST_WAIT) begin
        found = 1;
        ret_cyc = m_cyc;
        ret_slot = m_slot;
      end
    end
    chk("t2_returned_to_wait", 32'(found), 32'd1);
    chk("t2_return_cycle", 32'(ret_cyc), 32'd7);
    chk("t2_return_slot", 32'(ret_slot), 32'd1);
    chk("t2_no_start_busy_channel", 32'(n_start), 32'd0);
    channel_clear = 1'b1;
    serve("t2", 1, 4'b1000);

    // 3: SOS and heartbeat together; SOS first, heartbeat afterwards.
    do_reset();
    myTimeslot = 16'd3;
    req = 4'b1001;
    tick();
    chk("t3_grant", 32'(grant), 32'b0001);
    chk("t3_type", 32'(tx_type), 32'b110);
    serve("t3a", 3, 4'b0001);
    tick();
    chk("t3_hb_grant", 32'(grant), 32'b1000);
    chk("t3_hb_type", 32'(tx_type), 32'b000);
    serve("t3b", 3, 4'b1000);

    // 4: withdrawal in WAIT_SLOT.
    do_reset();
    req = 4'b0010;
    tick();
    chk("t4_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    req = 4'b0000;
    tick();
    chk("t4_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_grant", 32'(grant), 32'd0);
    chk("t4_ack", 32'(ack), 32'd0);
    chk("t4_tx_start", 32'(tx_start), 32'd0);

    // 5: reset mid-TX.
    do_reset();
    myTimeslot = 16'd1;
    req = 4'b0100;
    tick();
    wait_tx_start(40, "t5");
    tick();
    chk("t5_in_tx", 32'(dbg_state), 32'(ST_TX));
    nrst = 1'b0;
    req = 4'b0000;
    tick();
    nrst = 1'b1;
    chk("t5_rst_tx_start", 32'(tx_start), 32'd0);
    chk("t5_rst_tx_type", 32'(tx_type), 32'd0);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_ack", 32'(ack), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_slot", 32'(slot_count), 32'd0);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t5_late_done_no_ack", 32'(ack), 32'd0);
    chk("t5_late_done_idle", 32'(dbg_state), 32'(ST_IDLE));

    // 6: en=0 while sensing, then re-enable with request still held.
    do_reset();
    myTimeslot = 16'd0;
    channel_clear = 1'b0;
    req = 4'b0010;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick();
      if (dbg_state == ST_SENSE) found = 1;
    end
    chk("t6_reached_sense", 32'(found), 32'd1);
    en = 1'b0;
    tick();
    chk("t6_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_ack", 32'(ack), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_stays_idle", 32'(busy), 32'd0);
    en = 1'b1;
    channel_clear = 1'b1;
    tick();
    chk("t6_regrant", 32'(grant), 32'b0010);
    chk("t6_retype", 32'(tx_type), 32'b101);
    serve("t6", 0, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
